// File: rtl/ms13_peer.sv
// ms13_peer: far-side counterpart for the TestMasterSlave13 port group.
// Captures notified master values into a FIFO and keeps a running sum of them.
// Each queued value is replayed as two slave-input phases with one-cycle syncs.
//
// state | meaning
// SEC_A | idle; pop the head and emit phase 1 once the FIFO has data
// SEC_B | phase 2: emit hold + s_in
// SEC_C | phase 2 done; pop the next value straight away, or return to idle
module ms13_peer #(
  parameter int                 DEPTH  = 4,
  parameter logic signed [31:0] OFFSET = 32'sd1,
  localparam int                CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   m_in_data,
  input  logic          m_in_notify,
  output logic [31:0]   m_out_data,
  output logic [31:0]   s_out1,
  output logic          s_out1_sync,
  output logic [31:0]   s_out2,
  output logic          s_out2_sync,
  input  logic [31:0]   s_in,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {SEC_A = 2'd0, SEC_B = 2'd1, SEC_C = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hold_q, hold_d;
  logic [31:0]   sum_q, sum_d;
  logic [31:0]   s_out1_q, s_out1_d, s_out2_q, s_out2_d;
  logic          s1_sync_q, s1_sync_d, s2_sync_q, s2_sync_d;
  logic          overflow_q, overflow_d;
  logic          pop, push;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEC_A;
    else     state_q <= state_d;
  end

  // Next-state: A and C both start a new value when data is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEC_A:   state_d = (count_q != '0) ? SEC_B : SEC_A;
      SEC_B:   state_d = SEC_C;
      SEC_C:   state_d = (count_q != '0) ? SEC_B : SEC_A;
      default: state_d = SEC_A;
    endcase
  end

  // FSM outputs: pop the head for phase 1, or emit phase 2 from the hold value.
  always_comb begin
    pop       = 1'b0;
    hold_d    = hold_q;
    s_out1_d  = s_out1_q;
    s1_sync_d = 1'b0;
    s_out2_d  = s_out2_q;
    s2_sync_d = 1'b0;
    case (state_q)
      SEC_A, SEC_C: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          hold_d    = mem_q[rd_ptr_q];
          s_out1_d  = mem_q[rd_ptr_q] + OFFSET;
          s1_sync_d = 1'b1;
        end
      end
      SEC_B: begin
        s_out2_d  = hold_q + s_in;
        s2_sync_d = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    push       = m_in_notify && ((count_q < DEPTH_C) || pop);
    overflow_d = overflow_q | (m_in_notify & ~push);
    sum_d      = push ? (sum_q + m_in_data) : sum_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = m_in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      sum_q      <= '0;
      s_out1_q   <= '0;
      s_out2_q   <= '0;
      s1_sync_q  <= 1'b0;
      s2_sync_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      sum_q      <= sum_d;
      s_out1_q   <= s_out1_d;
      s_out2_q   <= s_out2_d;
      s1_sync_q  <= s1_sync_d;
      s2_sync_q  <= s2_sync_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_out_data  = sum_q;
  assign s_out1      = s_out1_q;
  assign s_out1_sync = s1_sync_q;
  assign s_out2      = s_out2_q;
  assign s_out2_sync = s2_sync_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ms13_peer.sv
// Bench for ms13_peer: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_ms13_peer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] OFFSET = 32'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   m_in_data;
  logic          m_in_notify;
  logic [31:0]   m_out_data;
  logic [31:0]   s_out1;
  logic          s_out1_sync;
  logic [31:0]   s_out2;
  logic          s_out2_sync;
  logic [31:0]   s_in;
  logic [CW-1:0] count;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of accepted values plus a "phase 2 owed" flag.
  logic [31:0] mq[$];
  logic [31:0] m_hold, e_s1, e_s2, e_sum;
  bit          e_s1s, e_s2s, e_ovf, s2_due;

  ms13_peer #(.DEPTH(DEPTH), .OFFSET(OFFSET)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_in_data   (m_in_data),
    .m_in_notify (m_in_notify),
    .m_out_data  (m_out_data),
    .s_out1      (s_out1),
    .s_out1_sync (s_out1_sync),
    .s_out2      (s_out2),
    .s_out2_sync (s_out2_sync),
    .s_in        (s_in),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic nt, input logic [31:0] d, input logic [31:0] si);
    bit do_pop;
    if (r) begin
      mq.delete();
      m_hold = 0; e_s1 = 0; e_s2 = 0; e_sum = 0;
      e_s1s = 0; e_s2s = 0; e_ovf = 0; s2_due = 0;
      return;
    end
    do_pop = !s2_due && (mq.size() > 0);
    e_s1s = 0;
    e_s2s = 0;
    if (s2_due) begin
      e_s2   = m_hold + si;
      e_s2s  = 1;
      s2_due = 0;
    end else if (do_pop) begin
      m_hold = mq.pop_front();
      e_s1   = m_hold + OFFSET;
      e_s1s  = 1;
      s2_due = 1;
    end
    if (nt) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(d);
        e_sum = e_sum + d;
      end else begin
        e_ovf = 1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input logic r, input logic nt, input logic [31:0] d, input logic [31:0] si);
    rst = r; m_in_notify = nt; m_in_data = d; s_in = si;
    @(posedge clk);
    model_edge(r, nt, d, si);
    #1;
    check_val("m_out_data", m_out_data, e_sum);
    check_val("s_out1", s_out1, e_s1);
    check_val("s_out1_sync", 32'(s_out1_sync), 32'(e_s1s));
    check_val("s_out2", s_out2, e_s2);
    check_val("s_out2_sync", 32'(s_out2_sync), 32'(e_s2s));
    check_val("count", 32'(count), 32'(mq.size()));
    check_val("overflow", 32'(overflow), 32'(e_ovf));
    check_val("syncs_exclusive", 32'(s_out1_sync & s_out2_sync), 32'd0);
  endtask

  initial begin
    rst = 1'b1; m_in_notify = 1'b0; m_in_data = '0; s_in = '0;

    // Reset state and single-value sequence.
    step(1, 0, 0, 5);
    step(1, 0, 0, 5);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_sum", m_out_data, 32'd0);
    step(0, 1, 32'd10, 5);
    check_val("t1_count", 32'(count), 32'd1);
    check_val("t1_sum", m_out_data, 32'd10);
    step(0, 0, 0, 5);
    check_val("t1_s1", s_out1, 32'd11);
    check_val("t1_s1s", 32'(s_out1_sync), 32'd1);
    step(0, 0, 0, 5);
    check_val("t1_s2", s_out2, 32'd15);
    check_val("t1_s2s", 32'(s_out2_sync), 32'd1);
    step(0, 0, 0, 5);
    check_val("t1_idle", 32'({s_out1_sync, s_out2_sync}), 32'd0);

    // Back-to-back 1,2,3: phase-1 pulses every other cycle, no gap.
    step(1, 0, 0, 0);
    step(0, 1, 32'd1, 0);
    step(0, 1, 32'd2, 0);
    step(0, 1, 32'd3, 0);
    check_val("t2_s1_a", s_out1, 32'd2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("t2_s1_b", s_out1, 32'd3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("t2_s1_c", s_out1, 32'd4);
    check_val("t2_sum", m_out_data, 32'd6);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Eight notifies: last one lands on a full FIFO while the head pops.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'(100 + i), 0);
    check_val("full_pop_count", 32'(count), 32'd4);
    check_val("full_pop_ovf", 32'(overflow), 32'd0);
    // Two more: the first hits a full FIFO with no pop and is dropped.
    for (int i = 0; i < 2; i++) step(0, 1, 32'(200 + i), 0);
    check_val("burst_ovf", 32'(overflow), 32'd1);
    check_val("burst_count_max", 32'(count <= CW'(4)), 32'd1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

    // Two's-complement wrap.
    step(1, 0, 0, 1);
    step(0, 1, 32'h7FFF_FFFF, 1);
    step(0, 0, 0, 1);
    check_val("wrap_s1", s_out1, 32'h8000_0000);
    step(0, 0, 0, 1);
    check_val("wrap_s2", s_out2, 32'h8000_0000);

    // Reset while phase 1 is pulsing with more data queued.
    step(1, 0, 0, 0);
    step(0, 1, 32'd7, 0);
    step(0, 1, 32'd8, 0);
    step(1, 1, 32'd9, 0);
    check_val("mid_rst_count", 32'(count), 32'd0);
    check_val("mid_rst_s1", s_out1, 32'd0);
    check_val("mid_rst_sync", 32'({s_out1_sync, s_out2_sync}), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
